// File: rtl/l2_arbiter_if.sv
// Bundle of the two L1 miss ports and the L2 mem port shared by the arbiter.
// The arbiter takes the slave view; the surrounding requesters and L2 drive the master view.
interface l2_arbiter_if #(
  parameter int s_line = 256,
  parameter int s_addr = 32
);
  logic [s_addr-1:0] i_mem_address;
  logic              i_mem_read;
  logic [s_line-1:0] i_mem_rdata;
  logic              i_mem_resp;

  logic [s_addr-1:0] d_mem_address;
  logic              d_mem_read;
  logic              d_mem_write;
  logic [s_line-1:0] d_mem_wdata;
  logic [s_line-1:0] d_mem_rdata;
  logic              d_mem_resp;

  logic [s_addr-1:0] l2_address;
  logic              l2_read;
  logic              l2_write;
  logic [s_line-1:0] l2_wdata;
  logic [s_line-1:0] l2_rdata;
  logic              l2_resp;

  modport slave (
    input  i_mem_address, i_mem_read,
    output i_mem_rdata, i_mem_resp,
    input  d_mem_address, d_mem_read, d_mem_write, d_mem_wdata,
    output d_mem_rdata, d_mem_resp,
    output l2_address, l2_read, l2_write, l2_wdata,
    input  l2_rdata, l2_resp
  );

  modport master (
    output i_mem_address, i_mem_read,
    input  i_mem_rdata, i_mem_resp,
    output d_mem_address, d_mem_read, d_mem_write, d_mem_wdata,
    input  d_mem_rdata, d_mem_resp,
    input  l2_address, l2_read, l2_write, l2_wdata,
    output l2_rdata, l2_resp
  );
endinterface

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing one L2 port between the L1 I-cache and D-cache.
// One transaction in flight; the L2 response is steered back to the granted side.
module l2_arbiter #(
  parameter int s_line = 256,
  parameter int s_addr = 32
) (
  input  logic          clk,
  input  logic          rst,
  l2_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [s_addr-1:0] l2_address_q, l2_address_d;
  logic [s_line-1:0] l2_wdata_q, l2_wdata_d;
  logic              l2_read_q, l2_read_d;
  logic              l2_write_q, l2_write_d;
  logic              i_req, d_req, grant_i, grant_d;
  logic              i_resp, d_resp;

  // Arbitration and next-state/command capture
  always_comb begin
    i_req   = bus.i_mem_read;
    d_req   = bus.d_mem_read | bus.d_mem_write;
    // last_grant = 1 means D went last, so I wins a tie
    grant_i = i_req & (~d_req | last_grant_q);
    grant_d = d_req & ~grant_i;

    state_d      = state_q;
    last_grant_d = last_grant_q;
    l2_address_d = l2_address_q;
    l2_wdata_d   = l2_wdata_q;
    l2_read_d    = l2_read_q;
    l2_write_d   = l2_write_q;

    case (state_q)
      IDLE: begin
        if (grant_i) begin
          state_d      = SERVE_I;
          last_grant_d = 1'b0;
          l2_address_d = bus.i_mem_address;
          l2_read_d    = 1'b1;
          l2_write_d   = 1'b0;
        end else if (grant_d) begin
          state_d      = SERVE_D;
          last_grant_d = 1'b1;
          l2_address_d = bus.d_mem_address;
          l2_wdata_d   = bus.d_mem_wdata;
          // Illegal read+write collapses to a write
          l2_read_d    = bus.d_mem_read & ~bus.d_mem_write;
          l2_write_d   = bus.d_mem_write;
        end else begin
          state_d = IDLE;
        end
      end
      SERVE_I, SERVE_D: begin
        if (bus.l2_resp) begin
          state_d    = IDLE;
          l2_read_d  = 1'b0;
          l2_write_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d    = IDLE;
        l2_read_d  = 1'b0;
        l2_write_d = 1'b0;
      end
    endcase
  end

  // State and L2 command registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      l2_address_q <= {s_addr{1'b0}};
      l2_wdata_q   <= {s_line{1'b0}};
      l2_read_q    <= 1'b0;
      l2_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      l2_address_q <= l2_address_d;
      l2_wdata_q   <= l2_wdata_d;
      l2_read_q    <= l2_read_d;
      l2_write_q   <= l2_write_d;
    end
  end

  // Same-cycle response steering; the idle side sees zeros
  always_comb begin
    i_resp          = (state_q == SERVE_I) & bus.l2_resp;
    d_resp          = (state_q == SERVE_D) & bus.l2_resp;
    bus.i_mem_resp  = i_resp;
    bus.d_mem_resp  = d_resp;
    bus.i_mem_rdata = i_resp ? bus.l2_rdata : {s_line{1'b0}};
    bus.d_mem_rdata = d_resp ? bus.l2_rdata : {s_line{1'b0}};
  end

  assign bus.l2_address = l2_address_q;
  assign bus.l2_wdata   = l2_wdata_q;
  assign bus.l2_read    = l2_read_q;
  assign bus.l2_write   = l2_write_q;

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: a transaction-level model tracks pending
// requests and round-robin history and predicts each L2 command and response.
module tb_l2_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  l2_arbiter_if #(.s_line(LW), .s_addr(AW)) ifc ();
  l2_arbiter #(.s_line(LW), .s_addr(AW)) dut (.clk(clk), .rst(rst), .bus(ifc));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: outstanding requests plus who was served last
  bit              i_pend, d_pend;
  logic [AW-1:0]   i_addr_m, d_addr_m;
  bit              d_rd_m, d_wr_m;
  logic [LW-1:0]   d_wdata_m;
  bit              exp_last;
  logic [LW-1:0]   exp_wdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW/32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic drive_reqs();
    ifc.i_mem_read    = i_pend;
    ifc.i_mem_address = i_addr_m;
    ifc.d_mem_read    = d_pend & d_rd_m;
    ifc.d_mem_write   = d_pend & d_wr_m;
    ifc.d_mem_address = d_addr_m;
    ifc.d_mem_wdata   = d_wdata_m;
  endtask

  task automatic new_i(input logic [AW-1:0] a);
    i_pend = 1'b1; i_addr_m = a;
    drive_reqs();
  endtask

  task automatic new_d(input logic [AW-1:0] a, input bit rd, input bit wr, input logic [LW-1:0] w);
    d_pend = 1'b1; d_addr_m = a; d_rd_m = rd; d_wr_m = wr; d_wdata_m = w;
    drive_reqs();
  endtask

  task automatic new_d_rand();
    int mode;
    mode = $urandom_range(0, 2);
    new_d($urandom, mode != 1, mode != 0, rand_line());
  endtask

  task automatic do_reset();
    i_pend = 1'b0; d_pend = 1'b0;
    drive_reqs();
    ifc.l2_resp = 1'b0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_last  = 1'b1;
    exp_wdata = '0;
  endtask

  // One complete arbitrated transaction, predicted from the pending set
  task automatic do_txn(input int lat, input bit perturb, input bit renew, output bit side);
    bit            win_d, e_rd, e_wr;
    int            n;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] data;
    side = 1'b0;
    if (!i_pend && !d_pend) begin
      n_tests++; n_fail++;
      $display("FAIL no_request: bench had nothing pending");
      return;
    end
    win_d  = (i_pend && d_pend) ? !exp_last : d_pend;
    e_addr = win_d ? d_addr_m : i_addr_m;
    e_wr   = win_d & d_wr_m;
    e_rd   = win_d ? (d_rd_m & !d_wr_m) : 1'b1;
    if (win_d) exp_wdata = d_wdata_m;
    exp_last = win_d;
    side     = win_d;

    n = 0;
    do begin tick(); n++; end while (!(ifc.l2_read || ifc.l2_write) && n < 20);
    n_tests++;
    if (n !== 1) begin
      n_fail++;
      $display("FAIL grant_latency: got %0d cycles, want 1", n);
      if (n >= 20) return;
    end
    n_tests++;
    if (ifc.l2_address !== e_addr || ifc.l2_read !== e_rd || ifc.l2_write !== e_wr) begin
      n_fail++;
      $display("FAIL cmd: got addr=%h rd=%b wr=%b, want addr=%h rd=%b wr=%b side=%0d",
               ifc.l2_address, ifc.l2_read, ifc.l2_write, e_addr, e_rd, e_wr, win_d);
    end
    n_tests++;
    if (ifc.l2_wdata !== exp_wdata) begin
      n_fail++;
      $display("FAIL wdata: got %h want %h", ifc.l2_wdata, exp_wdata);
    end

    for (int k = 0; k < lat; k++) begin
      if (perturb && k == 0) begin
        if (win_d) ifc.d_mem_address = $urandom;
        else       ifc.i_mem_address = $urandom;
      end
      ifc.l2_rdata = rand_line();
      #1;
      n_tests++;
      if (ifc.l2_address !== e_addr || ifc.l2_read !== e_rd || ifc.l2_write !== e_wr ||
          ifc.i_mem_resp !== 1'b0 || ifc.d_mem_resp !== 1'b0 ||
          ifc.i_mem_rdata !== '0 || ifc.d_mem_rdata !== '0) begin
        n_fail++;
        $display("FAIL hold: addr=%h rd=%b wr=%b iresp=%b dresp=%b, want addr=%h rd=%b wr=%b resps=0",
                 ifc.l2_address, ifc.l2_read, ifc.l2_write, ifc.i_mem_resp, ifc.d_mem_resp,
                 e_addr, e_rd, e_wr);
      end
      tick();
    end

    data = rand_line();
    ifc.l2_rdata = data;
    ifc.l2_resp  = 1'b1;
    #1;
    n_tests++;
    if (win_d ? (ifc.d_mem_resp !== 1'b1 || ifc.d_mem_rdata !== data ||
                 ifc.i_mem_resp !== 1'b0 || ifc.i_mem_rdata !== '0)
              : (ifc.i_mem_resp !== 1'b1 || ifc.i_mem_rdata !== data ||
                 ifc.d_mem_resp !== 1'b0 || ifc.d_mem_rdata !== '0)) begin
      n_fail++;
      $display("FAIL resp: side=%0d got iresp=%b dresp=%b irdata_ok=%b drdata_ok=%b",
               win_d, ifc.i_mem_resp, ifc.d_mem_resp,
               ifc.i_mem_rdata === (win_d ? '0 : data), ifc.d_mem_rdata === (win_d ? data : '0));
    end
    tick();
    ifc.l2_resp = 1'b0;
    n_tests++;
    if (ifc.l2_read !== 1'b0 || ifc.l2_write !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_gap: got rd=%b wr=%b want 0 0", ifc.l2_read, ifc.l2_write);
    end
    if (win_d) begin
      if (renew) new_d_rand(); else begin d_pend = 1'b0; drive_reqs(); end
    end else begin
      if (renew) new_i($urandom); else begin i_pend = 1'b0; drive_reqs(); end
    end
  endtask

  task automatic check_all_zero(input string name);
    n_tests++;
    if (ifc.l2_address !== '0 || ifc.l2_wdata !== '0 || ifc.l2_read !== 1'b0 ||
        ifc.l2_write !== 1'b0 || ifc.i_mem_resp !== 1'b0 || ifc.d_mem_resp !== 1'b0 ||
        ifc.i_mem_rdata !== '0 || ifc.d_mem_rdata !== '0) begin
      n_fail++;
      $display("FAIL %s: got addr=%h rd=%b wr=%b iresp=%b dresp=%b, want all 0",
               name, ifc.l2_address, ifc.l2_read, ifc.l2_write, ifc.i_mem_resp, ifc.d_mem_resp);
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_all_zero("reset_outputs");
  endtask

  task automatic test_single_i();
    bit side;
    new_i(32'h0000_1000);
    do_txn(3, 1'b0, 1'b0, side);
    n_tests++;
    if (side !== 1'b0) begin n_fail++; $display("FAIL single_i_side: got %0d want 0", side); end
  endtask

  task automatic test_d_write();
    bit side;
    new_d(32'h0000_2040, 1'b0, 1'b1, {8{32'h1234_5678}});
    do_txn(2, 1'b0, 1'b0, side);
    new_d($urandom, 1'b1, 1'b0, rand_line());
    do_txn(1, 1'b0, 1'b0, side);
    new_d($urandom, 1'b1, 1'b1, rand_line());
    do_txn(2, 1'b0, 1'b0, side);
  endtask

  task automatic test_idle_resp();
    ifc.l2_rdata = rand_line();
    ifc.l2_resp  = 1'b1;
    #1;
    n_tests++;
    if (ifc.i_mem_resp !== 1'b0 || ifc.d_mem_resp !== 1'b0 ||
        ifc.i_mem_rdata !== '0 || ifc.d_mem_rdata !== '0) begin
      n_fail++;
      $display("FAIL idle_resp: got iresp=%b dresp=%b want 0 0", ifc.i_mem_resp, ifc.d_mem_resp);
    end
    tick();
    ifc.l2_resp = 1'b0;
    n_tests++;
    if (ifc.l2_read !== 1'b0 || ifc.l2_write !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_resp_cmd: got rd=%b wr=%b want 0 0", ifc.l2_read, ifc.l2_write);
    end
  endtask

  task automatic test_tie();
    bit side;
    do_reset();
    new_i($urandom);
    new_d_rand();
    do_txn(2, 1'b0, 1'b0, side);
    n_tests++;
    if (side !== 1'b0) begin n_fail++; $display("FAIL tie_first: got %0d want 0(I)", side); end
    do_txn(2, 1'b0, 1'b0, side);
    n_tests++;
    if (side !== 1'b1) begin n_fail++; $display("FAIL tie_second: got %0d want 1(D)", side); end
    new_i($urandom);
    do_txn(1, 1'b0, 1'b0, side);
    new_i($urandom);
    new_d_rand();
    do_txn(3, 1'b0, 1'b0, side);
    n_tests++;
    if (side !== 1'b1) begin n_fail++; $display("FAIL tie_d_first: got %0d want 1(D)", side); end
    do_txn(1, 1'b0, 1'b0, side);
  endtask

  task automatic test_back_to_back();
    bit side;
    do_reset();
    new_i($urandom);
    new_d_rand();
    for (int k = 0; k < 8; k++) begin
      do_txn($urandom_range(1, 4), 1'b0, 1'b1, side);
      n_tests++;
      if (side !== bit'(k % 2)) begin
        n_fail++;
        $display("FAIL alternate[%0d]: got %0d want %0d", k, side, k % 2);
      end
    end
    i_pend = 1'b0; d_pend = 1'b0;
    drive_reqs();
  endtask

  task automatic test_addr_change();
    bit side;
    new_d($urandom, 1'b1, 1'b0, rand_line());
    do_txn(4, 1'b1, 1'b0, side);
    new_i($urandom);
    do_txn(3, 1'b1, 1'b0, side);
  endtask

  task automatic test_reset_mid();
    bit side;
    do_reset();
    new_d($urandom, 1'b0, 1'b1, rand_line());
    do_txn(1, 1'b0, 1'b0, side);
    new_i(32'h0000_3000);
    new_d_rand();
    tick();
    n_tests++;
    if (ifc.l2_read !== 1'b1 || ifc.l2_address !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL midrst_grant: got rd=%b addr=%h want 1 00003000", ifc.l2_read, ifc.l2_address);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("midrst_outputs");
    exp_last  = 1'b1;
    exp_wdata = '0;
    do_txn(2, 1'b0, 1'b0, side);
    n_tests++;
    if (side !== 1'b0) begin n_fail++; $display("FAIL midrst_regrant: got %0d want 0(I)", side); end
    do_txn(1, 1'b0, 1'b0, side);
  endtask

  task automatic test_random();
    bit side;
    for (int k = 0; k < 40; k++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) new_i($urandom);
      if (!d_pend && $urandom_range(0, 1) == 1) new_d_rand();
      if (!i_pend && !d_pend) new_i($urandom);
      do_txn($urandom_range(1, 5), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), side);
    end
    i_pend = 1'b0; d_pend = 1'b0;
    drive_reqs();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_pend = 1'b0; d_pend = 1'b0;
    i_addr_m = '0; d_addr_m = '0; d_rd_m = 1'b0; d_wr_m = 1'b0; d_wdata_m = '0;
    exp_last = 1'b1; exp_wdata = '0;
    drive_reqs();
    ifc.l2_rdata = '0;
    ifc.l2_resp  = 1'b0;
    test_reset();
    test_single_i();
    test_d_write();
    test_idle_resp();
    test_tie();
    test_back_to_back();
    test_addr_change();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
# l2_arbiter

Two-port arbiter that shares the single four-way L2 cache between the L1 instruction cache (read-only) and the L1 data cache (read/write). It sits between the two L1 miss ports and the L2 `mem_*` port, all 256-bit line-granular. It registers one transaction at a time and forwards the L2 response to the granted requester. Round-robin priority prevents starvation under continuous contention.

## Interface
Parameters:
- `s_line`, 256: line width in bits for all data buses.
- `s_addr`, 32: address width.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_mem_address`  in  32  I-side line address.
- `i_mem_read`  in  1  I-side read request; held high until `i_mem_resp`.
- `i_mem_rdata`  out  256  I-side read data; valid only while `i_mem_resp`.
- `i_mem_resp`  out  1  I-side one-cycle completion pulse.
- `d_mem_address`  in  32  D-side line address.
- `d_mem_read`  in  1  D-side read request; held until `d_mem_resp`.
- `d_mem_write`  in  1  D-side write request; held until `d_mem_resp`.
- `d_mem_wdata`  in  256  D-side write line.
- `d_mem_rdata`  out  256  D-side read data; valid only while `d_mem_resp`.
- `d_mem_resp`  out  1  D-side one-cycle completion pulse.
- `l2_address`  out  32  address to L2 `mem_address`.
- `l2_read`  out  1  to L2 `mem_read`.
- `l2_write`  out  1  to L2 `mem_write`.
- `l2_wdata`  out  256  to L2 `mem_wdata`.
- `l2_rdata`  in  256  from L2 `mem_rdata`.
- `l2_resp`  in  1  from L2 `mem_resp`.

## Operation
- States: IDLE, SERVE_I, SERVE_D.
- `last_grant` register, 1 bit: 0 = I, 1 = D. Reset value is 1, so I wins the first tie.
- IDLE: `i_req` = `i_mem_read`. `d_req` = `d_mem_read` | `d_mem_write`.
  - Only `i_req` asserted -> SERVE_I.
  - Only `d_req` asserted -> SERVE_D.
  - Both asserted -> grant the side opposite `last_grant`.
  - Neither asserted -> stay in IDLE.
- On grant, the following are captured into output registers:
  - `l2_address` gets the granted address.
  - `l2_wdata` gets `d_mem_wdata` on D grant; it holds its previous value on I grant.
  - `l2_read` / `l2_write` get the granted command.
  - `last_grant` is updated to the granted side.
- D side with read and write both high is illegal. The arbiter issues a write only (`l2_write`=1, `l2_read`=0).
- SERVE_x: L2 outputs hold constant until `l2_resp`.
  - In the `l2_resp` cycle, `x_mem_resp` = 1 combinationally and `x_mem_rdata` = `l2_rdata`.
  - At the same edge, `l2_read` and `l2_write` clear and the state goes to IDLE.
- The non-granted requester sees resp = 0 and rdata = 0. Its request stays pending and is arbitrated in the next IDLE.
- `l2_resp` while in IDLE is ignored: no requester resp is generated.
- Changes on requester inputs during SERVE_x are ignored; the latched values are used.

## Timing
- Reset (synchronous): state = IDLE, `last_grant` = 1, and all of the following are 0:
  - `l2_address`, `l2_wdata`, `l2_read`, `l2_write`
  - `i_mem_resp`, `d_mem_resp`, `i_mem_rdata`, `d_mem_rdata`
- Reset mid-transaction: the request is dropped and L2 commands are 0 the cycle after. The L2 shares `rst`, so no response is owed.
- Request in IDLE at cycle N -> `l2_read`/`l2_write` high from cycle N+1.
- `l2_resp` at cycle M -> requester resp at cycle M, same cycle.
- `l2_read`/`l2_write` are low at cycle M+1. The earliest next grant is sampled at M+1, so the L2 command is high again at M+2.
- Minimum one idle cycle on the L2 command between transactions.
- End-to-end latency = 1 + L2 latency cycles.
- Under continuous dual requests, grants strictly alternate I, D, I, D.

## Test plan
- Reset, then single I read at 0x0000_1000; L2 returns 0xAA..AA after 3 cycles.
  - `l2_read` high from cycle 1 with `l2_address` = 0x0000_1000.
  - `i_mem_resp` pulses once with `i_mem_rdata` = 0xAA..AA.
  - `d_mem_resp` stays 0.
- D write to 0x0000_2040 with wdata 0x1234..5678.
  - `l2_write`=1, `l2_read`=0, `l2_address`=0x0000_2040, `l2_wdata`=0x1234..5678.
  - `d_mem_resp` is high only in the `l2_resp` cycle.
- I and D request simultaneously right after reset.
  - I is served first; D is issued 2 cycles after I's resp.
  - A second simultaneous pair is then served D first.
- Both sides request continuously for 8 transactions -> grant order I, D, I, D, I, D, I, D, and each command is preceded by one idle cycle.
- D changes its address while SERVE_D is waiting -> `l2_address` keeps the latched value.
- Assert `rst` during SERVE_I -> next cycle state = IDLE and all outputs are 0. Pending requests are regranted from a fresh `last_grant` = 1.
